// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset / lock-supervision sequencer.
package pll_rst_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      FILTER    = 3'd2,
      STABLE    = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 50000;
   localparam int DEF_LOCK_FILTER    = 64;
   localparam int DEF_STAB_CYCLES    = 1024;
   localparam int DEF_RETRY_W        = 4;

   // Sized to hold the largest count itself, so a counter one past its terminal value cannot wrap.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      m = (m > d) ? m : d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, asynchronous active-high reset to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies its lock and releases the system reset once lock is stable.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
   parameter int STAB_CYCLES    = DEF_STAB_CYCLES,
   parameter int RETRY_W        = DEF_RETRY_W
) (
   input  logic               clkin,
   input  logic               reset,
   input  logic               pll_lock,
   output logic               pll_reset,
   output logic               sys_rst,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, STAB_CYCLES);
   localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] FLT_LAST  = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] STAB_LAST = CW'(STAB_CYCLES - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] phase_cnt, tmo_cnt;
   logic          lock_s, timeout, retry_inc, drop;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (clkin),
      .rst (reset),
      .d   (pll_lock),
      .q   (lock_s)
   );

   // >= so that a lock edge landing on the terminal count in WAIT_LOCK still times out in FILTER.
   assign timeout = (tmo_cnt >= TMO_LAST);

   always_comb begin
      state_nxt = state;
      retry_inc = 1'b0;
      drop      = 1'b0;
      case (state)
         PLL_RST:
            if (phase_cnt == RST_LAST) state_nxt = WAIT_LOCK;
         WAIT_LOCK:
            if (lock_s) state_nxt = FILTER;
            else if (timeout) begin
               state_nxt = PLL_RST;
               retry_inc = 1'b1;
            end
         FILTER:
            if (timeout) begin
               state_nxt = PLL_RST;
               retry_inc = 1'b1;
            end else if (!lock_s) state_nxt = WAIT_LOCK;
            else if (phase_cnt == FLT_LAST) state_nxt = STABLE;
         STABLE:
            if (!lock_s) begin
               state_nxt = PLL_RST;
               retry_inc = 1'b1;
               drop      = 1'b1;
            end else if (phase_cnt == STAB_LAST) state_nxt = RUN;
         RUN:
            if (!lock_s) begin
               state_nxt = PLL_RST;
               retry_inc = 1'b1;
               drop      = 1'b1;
            end
         default:
            state_nxt = PLL_RST;
      endcase
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state     <= PLL_RST;
         phase_cnt <= '0;
         tmo_cnt   <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state_nxt != state) phase_cnt <= '0;
         else if (state == PLL_RST || state == FILTER || state == STABLE) phase_cnt <= phase_cnt + 1'b1;

         // Glitches bounce FILTER<->WAIT_LOCK without clearing, so a flapping lock still times out.
         if (state == PLL_RST && state_nxt == WAIT_LOCK) tmo_cnt <= '0;
         else if (state == WAIT_LOCK || state == FILTER) tmo_cnt <= tmo_cnt + 1'b1;

         if (retry_inc && retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;

         pll_reset <= (state_nxt == PLL_RST);
         sys_rst   <= !(state == RUN && lock_s);
         ready     <= (state == RUN && lock_s);
         lock_lost <= drop;
      end
   end

endmodule
